// File: rtl/deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package deserializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } deser_state_t;

  // Shortest burst accepted when DESERIALIZER_MIN_LEN_EN is defined.
  localparam int unsigned MIN_BURST = 3;

endpackage

// File: rtl/deserializer.sv
// Reassembles MSB-first serial bursts into left-aligned words with a bit count.
// Optional DESERIALIZER_MIN_LEN_EN drops 1- and 2-bit bursts and pulses err_o instead.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MOD_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             ser_data_i,
  input  logic             ser_data_val_i,
  output logic [WIDTH-1:0] data_o,
  output logic [MOD_W-1:0] data_mod_o,
  output logic             data_val_o,
  output logic             busy_o,
  output logic             err_o
);

  deser_state_t state_q, state_d;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [MOD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [MOD_W-1:0] mod_q, mod_d;
  logic             val_q, val_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] mask;
  logic [MOD_W-1:0] cnt_inc;
  logic             emit;
  logic [WIDTH-1:0] emit_word;
  logic [MOD_W-1:0] emit_mod;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // A completed word returns to idle; a bit on the very next edge starts a fresh
  // word from idle, so back-to-back words lose no cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (ser_data_val_i) state_d = StCollect;
      StCollect: if (!ser_data_val_i || cnt_q == MOD_W'(WIDTH - 1)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign cnt_inc = cnt_q + MOD_W'(1);

  always_comb begin
    base      = (state_q == StCollect) ? shreg_q : '0;
    mask      = {1'b1, {(WIDTH-1){1'b0}}} >> cnt_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_word = '0;
    emit_mod  = '0;
    if (ser_data_val_i) begin
      shreg_d = ser_data_i ? (base | mask) : base;
      if (cnt_inc == MOD_W'(WIDTH)) begin
        emit      = 1'b1;
        emit_word = shreg_d;
        emit_mod  = cnt_inc;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (state_q == StCollect) begin
      emit      = 1'b1;
      emit_word = shreg_q;
      emit_mod  = cnt_q;
      cnt_d     = '0;
    end
  end

  always_comb begin
    data_d = data_q;
    mod_d  = mod_q;
    val_d  = 1'b0;
    err_d  = 1'b0;
    busy_d = (cnt_d != '0);
    if (emit) begin
`ifdef DESERIALIZER_MIN_LEN_EN
      if (emit_mod < MOD_W'(MIN_BURST)) begin
        err_d = 1'b1;
      end else begin
        data_d = emit_word;
        mod_d  = emit_mod;
        val_d  = 1'b1;
      end
`else
      data_d = emit_word;
      mod_d  = emit_mod;
      val_d  = 1'b1;
`endif
    end
  end

  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign data_val_o = val_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule
